// File: rtl/myca_ustore.sv
// myca_ustore: writable 16-word microprogram store with condition selector.
// The store is loaded through a valid/ready port. It drives a hold opcode
// until a complete 16-word program is present.
module myca_ustore #(
    parameter int unsigned CTLW = 7,
    localparam int unsigned WW = 9 + CTLW
) (
    input  logic            ck,
    input  logic            rst,
    input  logic [3:0]      pc,
    input  logic            wr_start,
    input  logic            wr_valid,
    input  logic [WW-1:0]   wr_data,
    output logic            wr_ready,
    output logic            loaded,
    input  logic [2:0]      flags,
    input  logic            flag_en,
    output logic [2:0]      opc,
    output logic [3:0]      dir,
    output logic            x,
    output logic [CTLW-1:0] ctl
);

    localparam logic [2:0] OPC_HOLD = 3'b111;
    localparam logic [3:0] LAST_ADDR = 4'd15;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      waddr_q, waddr_d;
    logic [2:0]      freg_q, freg_d;
    logic            mem_we;
    logic [WW-1:0]   mem_q [16];
    logic [WW-1:0]   rd_word;
    logic [1:0]      csel;

    // State, write address and flag registers
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            waddr_q <= 4'd0;
            freg_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            freg_q  <= freg_d;
        end
    end

    // Microword storage; contents survive reset and reloads until overwritten
    always_ff @(posedge ck) begin
        if (mem_we) begin
            mem_q[waddr_q] <= wr_data;
        end
    end

    // Next-state, write control and status decode; wr_start wins over a concurrent write
    always_comb begin
        state_d  = state_q;
        waddr_d  = waddr_q;
        mem_we   = 1'b0;
        wr_ready = 1'b0;
        loaded   = 1'b0;
        freg_d   = flag_en ? flags : freg_q;
        case (state_q)
            ST_EMPTY: begin
                if (wr_start) begin
                    state_d = ST_LOAD;
                    waddr_d = 4'd0;
                end
            end
            ST_LOAD: begin
                wr_ready = 1'b1;
                if (wr_start) begin
                    waddr_d = 4'd0;
                end else if (wr_valid) begin
                    mem_we  = 1'b1;
                    waddr_d = 4'(waddr_q + 4'd1);
                    if (waddr_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                loaded = 1'b1;
                if (wr_start) begin
                    state_d = ST_LOAD;
                    waddr_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                waddr_d = 4'd0;
            end
        endcase
    end

    // Zero-latency microword fields and condition select; hold opcode unless running
    always_comb begin
        rd_word = mem_q[pc];
        csel    = rd_word[WW-8:WW-9];
        opc     = OPC_HOLD;
        dir     = 4'd0;
        ctl     = '0;
        x       = 1'b0;
        if (state_q == ST_RUN) begin
            opc = rd_word[WW-1:WW-3];
            dir = rd_word[WW-4:WW-7];
            ctl = rd_word[CTLW-1:0];
            case (csel)
                2'd0:    x = freg_q[0];
                2'd1:    x = freg_q[1];
                2'd2:    x = freg_q[2];
                default: x = 1'b1;
            endcase
        end
    end

endmodule

// File: doc/myca_ustore.md
# myca_ustore

Writable 16-word microprogram store and condition selector for the MYCA controller. Sits directly downstream of the 4-bit microprogram sequencer: it receives `pc`, returns the current microword fields `opc`, `dir` and the selected condition bit `x`, and drives the datapath control lines `ctl`. Contents are loaded through a valid/ready write port. The sequencer is frozen with a hold opcode whenever no complete program is present.

## Interface
- `CTLW`, default 7: width of the control field. Microword width `WW` = 9 + `CTLW`.
- `ck`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  4  microprogram address from the sequencer.
- `wr_start`  in  1  single-cycle pulse that (re)starts a program load at address 0.
- `wr_valid`  in  1  write data valid.
- `wr_data`  in  WW  microword. Fields: [WW-1:WW-3] opc, [WW-4:WW-7] dir, [WW-8:WW-9] csel, [CTLW-1:0] ctl.
- `wr_ready`  out  1  store accepts a word this cycle.
- `loaded`  out  1  complete program present; store is running.
- `flags`  in  3  datapath status flags.
- `flag_en`  in  1  capture `flags` into the flag register.
- `opc`  out  3  opcode to the sequencer.
- `dir`  out  4  jump address to the sequencer.
- `x`  out  1  selected condition to the sequencer.
- `ctl`  out  CTLW  datapath control lines.

## Operation
- Storage: 16 x WW array, not reset. Registered write address `waddr` (4 bits), flag register `freg` (3 bits).
- FSM states: EMPTY, LOAD, RUN. Reset enters EMPTY.
- EMPTY:
  - `wr_start` -> LOAD. `waddr` <= 0.
- LOAD:
  - `wr_ready` = 1.
  - On `wr_valid & wr_ready`: mem[`waddr`] <= `wr_data`; `waddr` <= `waddr`+1.
  - The write at `waddr`=15 -> RUN. `waddr` wraps to 0.
- RUN:
  - `wr_start` -> LOAD. `waddr` <= 0. Memory contents are kept until overwritten.
- `wr_start` in LOAD: restarts at address 0.
  - A word presented in the same cycle is dropped.
  - `wr_start` has priority over a concurrent write.
- `wr_ready` is 0 in EMPTY and RUN. `wr_valid` outside LOAD is ignored.
- `loaded` = 1 only in RUN.
- Outputs in RUN:
  - `opc`, `dir`, `ctl` are the fields of mem[`pc`].
  - `x` = `freg`[csel] for csel 0..2; `x` = 1 for csel=3.
- Outputs in EMPTY and LOAD: `opc`=3'b111 (the sequencer holds `pc`), `dir`=0, `ctl`=0, `x`=0.
- Flag register:
  - `flag_en`=1: `freg` <= `flags` on the edge.
  - Otherwise `freg` holds.
  - Independent of the FSM state.
- Reset mid-load: returns to EMPTY and `loaded`=0. A partial program is never executed; a full reload is required.

## Timing
- Reset values: state EMPTY, `waddr`=0, `freg`=0, `wr_ready`=0, `loaded`=0, `opc`=3'b111, `dir`=0, `x`=0, `ctl`=0.
- `wr_ready` and `loaded` are decoded from the registered state and have no combinational input dependence.
- `wr_start` at edge k: `wr_ready`=1 from cycle k+1. The first write can occur at edge k+1.
- 16 back-to-back writes complete in 16 cycles. `loaded`=1 and valid outputs appear in the cycle after the 16th accepting edge.
- `opc`, `dir`, `ctl`, `x` are combinational from `pc`, the memory, `freg` and the state. The path is zero-latency: the sequencer's next edge sees the word for the current `pc`.
- A write to mem[a] during RUN is impossible, so there is no read/write collision.
- `flags` captured at edge k affect `x` from cycle k+1.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> all outputs immediately take their reset values; `opc`=3'b111 while `pc` toggles.
- Load 16 words, word i = {3'b000, i[3:0], 2'b11, 7'h0+i}, with `wr_valid` held high -> `wr_ready` high for exactly 16 cycles; `loaded` rises one cycle after the 16th edge; `pc`=5 gives `dir`=5, `ctl`=5, `x`=1.
- Condition select: word at pc 2 = {3'b010, 4'hA, 2'b01, ...}, `flags`=3'b010 with `flag_en` pulsed -> `x`=1 the next cycle; with `flags`=3'b000 captured -> `x`=0; with `flag_en`=0 and `flags` changed -> `x` unchanged.
- Gapped load: deassert `wr_valid` on every third cycle -> exactly 16 accepted words; `waddr` advances only on accepts; contents match the data sent.
- Restart in LOAD: `wr_start` together with `wr_valid` at word 7 -> that word is dropped; the next accepted word lands at address 0; `loaded` rises after 16 more accepts.
- Reload and reset: `wr_start` in RUN -> `loaded`=0 and `opc`=3'b111 the next cycle; `rst` after 8 words -> EMPTY; `wr_valid` alone then produces no write and `wr_ready` stays 0.
